// File: rtl/secded_ecc_memory.sv
// secded_ecc_memory: extended-Hamming SECDED word memory with post-reset init, scrubber, write-back, error counters.
// Latency: read response pulses 2 cycles after acceptance; writes land on the accepting edge.
// Backpressure: req_ready only in IDLE (RD/CHK/WB/INIT stall requests); responses cannot be stalled. SECDED_ERR_INJECT_EN adds an inject port.
module secded_ecc_memory #(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16,
  // Smallest P with 2**P >= DATA_W+P+1, i.e. DATA_W <= 2**P-P-1.
  localparam int P    = (DATA_W <= 4)   ? 3 : (DATA_W <= 11)  ? 4 :
                        (DATA_W <= 26)  ? 5 : (DATA_W <= 57)  ? 6 :
                        (DATA_W <= 120) ? 7 : (DATA_W <= 247) ? 8 :
                        (DATA_W <= 502) ? 9 : 10,
  localparam int CW_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_sbe,
  output logic              rsp_dbe,
  output logic [CNT_W-1:0]  sbe_count,
  output logic [CNT_W-1:0]  dbe_count,
  output logic              init_done
`ifdef SECDED_ERR_INJECT_EN
  ,
  input  logic              inj_valid,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [CW_W-1:0]   inj_mask
`endif
);

  localparam int IC_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CHK, S_WB} state_t;

  // XOR of the indices of all set Hamming positions (bit 0 excluded).
  function automatic logic [P-1:0] syndrome(input logic [CW_W-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int i = 1; i < CW_W; i++)
      if (cw[i]) s = s ^ P'(i);
    return s;
  endfunction

  // Data bits sit in non-power-of-2 positions, ascending LSB first.
  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    logic [P-1:0]    s;
    int              di;
    cw = '0;
    di = 0;
    for (int i = 1; i < CW_W; i++)
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[di];
        di++;
      end
    // Parity bit 2**j cancels bit j of the data-only syndrome.
    s = syndrome(cw);
    for (int j = 0; j < P; j++)
      cw[1 << j] = s[j];
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] cw_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int                di;
    d  = '0;
    di = 0;
    for (int i = 1; i < CW_W; i++)
      if ((i & (i - 1)) != 0) begin
        d[di] = cw[i];
        di++;
      end
    return d;
  endfunction

  logic [CW_W-1:0]   mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] op_addr;     // init pointer in INIT, operation address otherwise
  logic              op_scrub;
  logic [CW_W-1:0]   rd_cw;       // raw word in CHK, corrected word in WB
  logic [ADDR_W-1:0] scrub_addr;
  logic [IC_W-1:0]   idle_cnt;
  logic              scrub_pending;
  logic              scrub_hit;
  logic              inj_act;

  logic [P-1:0]      syn;
  logic              is_sbe;
  logic              is_dbe;
  logic [CW_W-1:0]   cw_fix;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CW_W-1:0]   mem_wdata;

`ifdef SECDED_ERR_INJECT_EN
  assign inj_act = inj_valid;
`else
  assign inj_act = 1'b0;
`endif

  assign scrub_hit = (SCRUB_INTERVAL != 0) && (idle_cnt == IC_W'(SCRUB_INTERVAL - 1));

  // Decode the registered codeword: classify and build the corrected word.
  always_comb begin
    syn    = syndrome(rd_cw);
    is_sbe = 1'b0;
    is_dbe = 1'b0;
    cw_fix = rd_cw;
    if (^rd_cw) begin
      if (int'(syn) >= CW_W) begin
        is_dbe = 1'b1;
      end else begin
        is_sbe      = 1'b1;
        cw_fix[syn] = ~rd_cw[syn];
      end
    end else if (syn != '0) begin
      is_dbe = 1'b1;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_CHK) && !op_scrub;
  assign rsp_data  = rsp_valid ? cw_data(cw_fix) : '0;
  assign rsp_sbe   = rsp_valid && is_sbe;
  assign rsp_dbe   = rsp_valid && is_dbe;

  // Select the single array write source for this cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = op_addr;
    mem_wdata = '0;
    case (state)
      S_INIT: mem_we = 1'b1;
      S_IDLE: begin
        if (req_valid && req_wr) begin
          mem_we    = 1'b1;
          mem_waddr = req_addr;
          mem_wdata = encode(req_wdata);
        end
`ifdef SECDED_ERR_INJECT_EN
        else if (!req_valid && inj_valid) begin
          mem_we    = 1'b1;
          mem_waddr = inj_addr;
          mem_wdata = mem[inj_addr] ^ inj_mask;
        end
`endif
      end
      S_WB: begin
        mem_we    = 1'b1;
        mem_wdata = rd_cw;
      end
      default: ;
    endcase
  end

  // Array storage is deliberately unreset; INIT clears it after reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control FSM with scrub scheduling and saturating error counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_INIT;
      op_addr       <= '0;
      op_scrub      <= 1'b0;
      rd_cw         <= '0;
      scrub_addr    <= '0;
      idle_cnt      <= '0;
      scrub_pending <= 1'b0;
      sbe_count     <= '0;
      dbe_count     <= '0;
      init_done     <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (op_addr == ADDR_W'(DEPTH - 1)) begin
            op_addr   <= '0;
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            op_addr <= op_addr + 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            if (!req_wr) begin
              op_addr  <= req_addr;
              op_scrub <= 1'b0;
              state    <= S_RD;
            end
          end else begin
            if (scrub_hit) idle_cnt <= '0;
            else if (SCRUB_INTERVAL != 0) idle_cnt <= idle_cnt + 1'b1;
            // Injection takes the idle slot; a pending scrub waits for the next one.
            if (scrub_pending && !inj_act) begin
              op_addr    <= scrub_addr;
              op_scrub   <= 1'b1;
              state      <= S_RD;
              scrub_addr <= (scrub_addr == ADDR_W'(DEPTH - 1)) ? '0 : scrub_addr + 1'b1;
            end
            scrub_pending <= scrub_hit || (scrub_pending && inj_act);
          end
        end
        S_RD: begin
          rd_cw <= mem[op_addr];
          state <= S_CHK;
        end
        S_CHK: begin
          if (is_sbe && (sbe_count != {CNT_W{1'b1}})) sbe_count <= sbe_count + 1'b1;
          if (is_dbe && (dbe_count != {CNT_W{1'b1}})) dbe_count <= dbe_count + 1'b1;
          if (is_sbe) begin
            rd_cw <= cw_fix;
            state <= S_WB;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WB: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_ecc_memory.sv
// Directed bench for secded_ecc_memory (8-bit data, 256 words, scrub every 16 idle clocks).
// Read responses are checked against a queue of expectations pushed at request acceptance.
// Errors are planted through the inject port when built with it, otherwise directly in the array.
module tb_secded_ecc_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_sbe;
  logic        rsp_dbe;
  logic [15:0] sbe_count;
  logic [15:0] dbe_count;
  logic        init_done;
  logic        inj_valid;
  logic [7:0]  inj_addr;
  logic [12:0] inj_mask;

  typedef struct {
    logic [7:0] data;
    logic       sbe;
    logic       dbe;
    int         acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  secded_ecc_memory #(
    .DATA_W(8), .DEPTH(256), .SCRUB_INTERVAL(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_sbe(rsp_sbe), .rsp_dbe(rsp_dbe),
    .sbe_count(sbe_count), .dbe_count(dbe_count), .init_done(init_done)
`ifdef SECDED_ERR_INJECT_EN
    , .inj_valid(inj_valid), .inj_addr(inj_addr), .inj_mask(inj_mask)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      check("rsp_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_sbe", rsp_sbe, e.sbe);
        check("rsp_dbe", rsp_dbe, e.dbe);
        check("rsp_latency", cyc - e.acc_cyc, 2);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] ed, input logic es, input logic edb);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", req_ready, 1);
    if (!wr) sb_q.push_back('{ed, es, edb, cyc});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Cycles with req_ready low right after an accepted read.
  task automatic ready_low(input string tag, input int exp_n);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_n);
  endtask

  task automatic inject(input logic [7:0] addr, input logic [12:0] mask);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
`ifdef SECDED_ERR_INJECT_EN
    inj_valid = 1'b1;
    inj_addr  = addr;
    inj_mask  = mask;
    @(posedge clk);
    #1 inj_valid = 1'b0;
`else
    dut.mem[addr] = dut.mem[addr] ^ mask;
`endif
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, 256);
    check("ready_after_init", req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wr_a [4] = '{8'h03, 8'h80, 8'hFF, 8'h00};
    logic [7:0] wr_d [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h5A};
    int         n;

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    inj_valid = 1'b0; inj_addr = '0; inj_mask = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_sbe_count", sbe_count, 0);
    check("rst_dbe_count", dbe_count, 0);
    rst_n = 1'b1;

    // 1: init sweep, then an untouched address reads back as clean zero.
    wait_init("init_cycles");
    do_req(1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
    ready_low("ready_low_rd10", 2);

    // 2: writes across several patterns incl. top address, read back clean.
    for (int i = 0; i < 4; i++) do_req(1'b1, wr_a[i], wr_d[i], 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_req(1'b0, wr_a[i], 8'h00, wr_d[i], 1'b0, 1'b0);
    do_req(1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 1'b0);
    ready_low("ready_low_clean", 2);

    // 3: flipped parity bit 4 -> corrected, write-back holds ready low one extra cycle.
    inject(8'h03, 13'h0010);
    do_req(1'b0, 8'h03, 8'h00, 8'hA5, 1'b1, 1'b0);
    ready_low("ready_low_sbe", 3);
    check("sbe_count_1", sbe_count, 1);
    do_req(1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 1'b0);
    ready_low("ready_low_after_wb", 2);
    // Position 12 carries d7: 0x3C is corrected back from 0xBC.
    inject(8'h80, 13'h1000);
    do_req(1'b0, 8'h80, 8'h00, 8'h3C, 1'b1, 1'b0);
    ready_low("ready_low_sbe_d7", 3);
    check("sbe_count_2", sbe_count, 2);

    // 4: bits 4 and 5 flipped -> DBE; bit 5 is d1 so raw data reads 0xA7. No write-back.
    inject(8'h03, 13'h0030);
    do_req(1'b0, 8'h03, 8'h00, 8'hA7, 1'b0, 1'b1);
    ready_low("ready_low_dbe1", 2);
    do_req(1'b0, 8'h03, 8'h00, 8'hA7, 1'b0, 1'b1);
    ready_low("ready_low_dbe2", 2);
    check("dbe_count_2", dbe_count, 2);
    check("sbe_count_after_dbe", sbe_count, 2);

    // 5: clear the DBE word, flip overall parity at 0x00 and let the scrubber find it.
    do_req(1'b1, 8'h03, 8'h5A, 8'h00, 1'b0, 1'b0);
    inject(8'h00, 13'h0001);
    n = 0;
    while (sbe_count == 16'd2 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("scrub_sbe_count", sbe_count, 3);
    check("scrub_dbe_count", dbe_count, 2);
    do_req(1'b0, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0);
    ready_low("ready_low_scrubbed", 2);

    // 6: reset asserted in the write-back cycle aborts everything and reruns init.
    inject(8'h03, 13'h0010);
    do_req(1'b0, 8'h03, 8'h00, 8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("wb_ready_low", req_ready, 0);
    check("wb_sbe_count", sbe_count, 4);
    rst_n = 1'b0;
    #1;
    check("rst2_sbe_count", sbe_count, 0);
    check("rst2_dbe_count", dbe_count, 0);
    check("rst2_init_done", init_done, 0);
    check("rst2_rsp_valid", rsp_valid, 0);
    check("rst2_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_cycles_2");
    do_req(1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    ready_low("ready_low_post_rst", 2);
    check("final_sbe_count", sbe_count, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
